// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between the CPU data path and the debug/DMA
// port: one access per cycle, round-robin on contention, read data routed by owner tag.
module mem_port_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // last_owner | meaning
    // OWN_CPU    | CPU took the most recent grant, DBG wins the next contest
    // OWN_DBG    | DBG took the most recent grant (reset value), CPU wins the next contest
    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    owner_e            last_owner_q, last_owner_d;
    logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0] tag_own_q, tag_own_d;
    logic              grant_cpu, grant_dbg;
    logic              rd_fire;

    // Grants are suppressed during reset so nothing reaches memory while rst is high.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (!rst) begin
            if (cpu_req && dbg_req) begin
                grant_cpu = (last_owner_q == OWN_DBG);
                grant_dbg = (last_owner_q == OWN_CPU);
            end else begin
                grant_cpu = cpu_req;
                grant_dbg = dbg_req;
            end
        end
    end

    always_comb begin
        mem_en    = grant_cpu | grant_dbg;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (grant_dbg) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    assign cpu_gnt = grant_cpu;
    assign dbg_gnt = grant_dbg;
    assign rd_fire = mem_en && !mem_we;

    // Tag bit 0 enters the pipe each cycle; the oldest tag falls off the top.
    always_comb begin
        last_owner_d = last_owner_q;
        if (grant_cpu) begin
            last_owner_d = OWN_CPU;
        end else if (grant_dbg) begin
            last_owner_d = OWN_DBG;
        end
        tag_vld_d = (tag_vld_q << 1) | RD_LAT'(rd_fire);
        tag_own_d = (tag_own_q << 1) | RD_LAT'(rd_fire && grant_dbg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_DBG;
            tag_vld_q    <= '0;
            tag_own_q    <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            tag_vld_q    <= tag_vld_d;
            tag_own_q    <= tag_own_d;
        end
    end

    always_comb begin
        cpu_rvalid = tag_vld_q[RD_LAT-1] && !tag_own_q[RD_LAT-1];
        dbg_rvalid = tag_vld_q[RD_LAT-1] &&  tag_own_q[RD_LAT-1];
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (read latency 1, 2, 3) share the same
// requester stimulus, each with its own memory model; a timeline scoreboard checks all.
module tb_mem_port_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int NI = 3;
    localparam int NV = 16;

    logic          clk;
    logic          rst;
    logic          cpu_req, cpu_we, dbg_req, dbg_we;
    logic [AW-1:0] cpu_addr, dbg_addr;
    logic [DW-1:0] cpu_wdata, dbg_wdata;

    logic          cpu_gnt_w    [NI];
    logic          dbg_gnt_w    [NI];
    logic          cpu_rvalid_w [NI];
    logic          dbg_rvalid_w [NI];
    logic [DW-1:0] cpu_rdata_w  [NI];
    logic [DW-1:0] dbg_rdata_w  [NI];
    logic          mem_en_w     [NI];
    logic          mem_we_w     [NI];
    logic [AW-1:0] mem_addr_w   [NI];
    logic [DW-1:0] mem_wdata_w  [NI];
    logic [DW-1:0] mem_rdata_w  [NI];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    function automatic logic [DW-1:0] init_word(int a);
        return 32'hA5C3_0000 ^ (32'(a) * 32'h0101_0107) ^ 32'h0000_005A;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = g + 1;
        logic [DW-1:0] mem  [256];
        logic [DW-1:0] pipe [L];

        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .cpu_req    (cpu_req),
            .cpu_we     (cpu_we),
            .cpu_addr   (cpu_addr),
            .cpu_wdata  (cpu_wdata),
            .cpu_gnt    (cpu_gnt_w[g]),
            .cpu_rvalid (cpu_rvalid_w[g]),
            .cpu_rdata  (cpu_rdata_w[g]),
            .dbg_req    (dbg_req),
            .dbg_we     (dbg_we),
            .dbg_addr   (dbg_addr),
            .dbg_wdata  (dbg_wdata),
            .dbg_gnt    (dbg_gnt_w[g]),
            .dbg_rvalid (dbg_rvalid_w[g]),
            .dbg_rdata  (dbg_rdata_w[g]),
            .mem_en     (mem_en_w[g]),
            .mem_we     (mem_we_w[g]),
            .mem_addr   (mem_addr_w[g]),
            .mem_wdata  (mem_wdata_w[g]),
            .mem_rdata  (mem_rdata_w[g])
        );

        assign mem_rdata_w[g] = pipe[L-1];

        // Synchronous memory with L-cycle read latency; idle cycles push garbage.
        initial begin
            for (int i = 0; i < 256; i++) mem[i] = init_word(i);
            for (int i = 0; i < L; i++) pipe[i] = '0;
            forever begin
                @(posedge clk);
                for (int i = L - 1; i > 0; i--) pipe[i] <= pipe[i-1];
                if (mem_en_w[g] && mem_we_w[g]) begin
                    mem[mem_addr_w[g][7:0]] <= mem_wdata_w[g];
                    pipe[0] <= $urandom;
                end else if (mem_en_w[g]) begin
                    pipe[0] <= mem[mem_addr_w[g][7:0]];
                end else begin
                    pipe[0] <= $urandom;
                end
            end
        end
    end

    // Reference: memory image, round-robin owner, and a timeline of read grants by cycle.
    logic [DW-1:0] ref_mem [256];
    bit            ref_last_dbg;
    bit            hist_vld  [8];
    bit            hist_dbg  [8];
    logic [DW-1:0] hist_data [8];
    bit            e_cg, e_dg, prev_cg, prev_dg;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void compute_grant();
        e_cg = 1'b0;
        e_dg = 1'b0;
        if (!rst) begin
            if (cpu_req && dbg_req) begin
                if (ref_last_dbg) e_cg = 1'b1;
                else              e_dg = 1'b1;
            end else begin
                e_cg = cpu_req;
                e_dg = dbg_req;
            end
        end
    endfunction

    function automatic void model_reset();
        ref_last_dbg = 1'b1;
        for (int i = 0; i < 8; i++) hist_vld[i] = 1'b0;
    endfunction

    task automatic model_check();
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd, ed;
        bit            ewe, v, ecr, edr;
        int            idx;
        compute_grant();
        ea  = e_cg ? cpu_addr  : (e_dg ? dbg_addr  : '0);
        ewd = e_cg ? cpu_wdata : (e_dg ? dbg_wdata : '0);
        ewe = e_cg ? cpu_we    : (e_dg ? dbg_we    : 1'b0);
        for (int k = 0; k < NI; k++) begin
            idx = (cyc - (k + 1) + 8) % 8;
            v   = hist_vld[idx];
            ecr = v && !hist_dbg[idx];
            edr = v &&  hist_dbg[idx];
            ed  = hist_data[idx];
            check($sformatf("L%0d ctl", k + 1),
                  {cpu_gnt_w[k], dbg_gnt_w[k], mem_en_w[k], mem_we_w[k], cpu_rvalid_w[k], dbg_rvalid_w[k]},
                  {e_cg, e_dg, e_cg | e_dg, ewe, ecr, edr});
            check($sformatf("L%0d mem_addr", k + 1), mem_addr_w[k], ea);
            check($sformatf("L%0d mem_wdata", k + 1), mem_wdata_w[k], ewd);
            check($sformatf("L%0d cpu_rdata", k + 1), cpu_rdata_w[k], ecr ? ed : 32'h0);
            check($sformatf("L%0d dbg_rdata", k + 1), dbg_rdata_w[k], edr ? ed : 32'h0);
        end
    endtask

    function automatic void model_update();
        int            s;
        bit            d, we;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        s = cyc % 8;
        compute_grant();
        hist_vld[s] = 1'b0;
        if (e_cg || e_dg) begin
            d  = e_dg;
            we = d ? dbg_we    : cpu_we;
            a  = d ? dbg_addr  : cpu_addr;
            wd = d ? dbg_wdata : cpu_wdata;
            ref_last_dbg = d;
            if (we) begin
                ref_mem[a[7:0]] = wd;
            end else begin
                hist_vld[s]  = 1'b1;
                hist_dbg[s]  = d;
                hist_data[s] = ref_mem[a[7:0]];
            end
        end
        prev_cg = e_cg;
        prev_dg = e_dg;
        cyc++;
    endfunction

    task automatic settle();
        #1;
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_in(bit creq, bit cwe, int ca, logic [DW-1:0] cwd,
                          bit dreq, bit dwe, int da, logic [DW-1:0] dwd);
        cpu_req = creq; cpu_we = cwe; cpu_addr = AW'(ca); cpu_wdata = cwd;
        dbg_req = dreq; dbg_we = dwe; dbg_addr = AW'(da); dbg_wdata = dwd;
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        advance();
        rst = 1'b0;
    endtask

    typedef struct {
        bit            r;
        bit            creq, cwe;
        int            ca;
        logic [DW-1:0] cwd;
        bit            dreq, dwe;
        int            da;
        logic [DW-1:0] dwd;
        bit            e_cg, e_dg, e_crv, e_drv;
        logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(bit r, bit creq, bit cwe, int ca, logic [DW-1:0] cwd,
                                bit dreq, bit dwe, int da, logic [DW-1:0] dwd,
                                bit ecg, bit edg, bit ecrv, bit edrv, logic [DW-1:0] erd);
        vec_t v;
        v.r = r; v.creq = creq; v.cwe = cwe; v.ca = ca; v.cwd = cwd;
        v.dreq = dreq; v.dwe = dwe; v.da = da; v.dwd = dwd;
        v.e_cg = ecg; v.e_dg = edg; v.e_crv = ecrv; v.e_drv = edrv; v.e_rd = erd;
        return v;
    endfunction

    vec_t tbl [NV];

    initial begin
        logic [AW-1:0] ea;
        // Expectations below are for the latency-1 instance.
        tbl[0]  = mk(1, 1, 0, 'h10, 0,            0, 0, 0,    0,            0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0,    0,            1, 1, 'h10, 32'hDEADBEEF, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 'h10, 0,            0, 0, 0,    0,            1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 1, 0, 32'hDEADBEEF);
        tbl[4]  = mk(1, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1,    0,            1, 0, 2,    0,            1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 1,    0,            1, 0, 2,    0,            0, 1, 1, 0, init_word(1));
        tbl[7]  = mk(0, 1, 0, 1,    0,            1, 0, 2,    0,            1, 0, 0, 1, init_word(2));
        tbl[8]  = mk(0, 1, 0, 1,    0,            1, 0, 2,    0,            0, 1, 1, 0, init_word(1));
        tbl[9]  = mk(0, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 0, 1, init_word(2));
        tbl[10] = mk(0, 1, 1, 'h20, 32'h12345678, 0, 0, 0,    0,            1, 0, 0, 0, 0);
        tbl[11] = mk(0, 0, 0, 0,    0,            1, 0, 'h20, 0,            0, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 0, 1, 32'h12345678);
        tbl[13] = mk(0, 1, 0, 5,    0,            1, 0, 'h30, 0,            1, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 1, 0, init_word(5));
        tbl[15] = mk(0, 0, 0, 0,    0,            0, 0, 0,    0,            0, 0, 0, 0, 0);

        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        prev_cg = 1'b0;
        prev_dg = 1'b0;
        rst = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].r;
            if (rst) model_reset();
            set_in(tbl[i].creq, tbl[i].cwe, tbl[i].ca, tbl[i].cwd,
                   tbl[i].dreq, tbl[i].dwe, tbl[i].da, tbl[i].dwd);
            settle();
            ea = tbl[i].e_cg ? AW'(tbl[i].ca) : (tbl[i].e_dg ? AW'(tbl[i].da) : '0);
            check("tbl gnt", {cpu_gnt_w[0], dbg_gnt_w[0]}, {tbl[i].e_cg, tbl[i].e_dg});
            check("tbl mem_addr", {mem_en_w[0], mem_addr_w[0]}, {tbl[i].e_cg | tbl[i].e_dg, ea});
            check("tbl rvalid", {cpu_rvalid_w[0], dbg_rvalid_w[0]}, {tbl[i].e_crv, tbl[i].e_drv});
            check("tbl rdata", {cpu_rdata_w[0], dbg_rdata_w[0]},
                  {tbl[i].e_crv ? tbl[i].e_rd : 32'h0, tbl[i].e_drv ? tbl[i].e_rd : 32'h0});
            advance();
        end

        // Latency-3 sweep: reads of 0..3 back-to-back return in cycles 3..6, in order.
        reset_cycle();
        for (int t = 0; t < 8; t++) begin
            set_in(t < 4, 0, t, 0, 0, 0, 0, 0);
            settle();
            check("sweep gnt", cpu_gnt_w[2], t < 4);
            check("sweep rvalid", {cpu_rvalid_w[2], dbg_rvalid_w[2]}, {t >= 3 && t <= 6, 1'b0});
            check("sweep rdata", cpu_rdata_w[2], (t >= 3 && t <= 6) ? init_word(t - 3) : 32'h0);
            advance();
        end

        // Latency-2 read in flight when reset pulses: it must never surface.
        reset_cycle();
        set_in(1, 0, 7, 0, 0, 0, 0, 0);
        settle();
        check("midrst gnt0", cpu_gnt_w[1], 1'b1);
        advance();
        set_in(1, 0, 9, 0, 0, 0, 0, 0);
        settle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        model_check();
        check("midrst ctl", {cpu_gnt_w[1], dbg_gnt_w[1], mem_en_w[1], mem_we_w[1], cpu_rvalid_w[1], dbg_rvalid_w[1]}, 6'b0);
        check("midrst mem", {mem_addr_w[1], mem_wdata_w[1]}, 64'h0);
        advance();
        rst = 1'b0;
        for (int t = 2; t < 4; t++) begin
            set_in(0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            check("midrst rvalid", {cpu_rvalid_w[1], dbg_rvalid_w[1]}, 2'b00);
            check("midrst rdata", {cpu_rdata_w[1], dbg_rdata_w[1]}, 64'h0);
            advance();
        end
        set_in(1, 0, 3, 0, 1, 0, 4, 0);
        settle();
        check("midrst contest", {cpu_gnt_w[1], dbg_gnt_w[1]}, 2'b10);
        advance();

        // Random traffic with held-until-granted requests, withdrawals and async resets.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        prev_cg = 1'b0;
        prev_dg = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst = 1'b0;
            if (cpu_req && !prev_cg) begin
                if ($urandom_range(0, 7) == 0) cpu_req = 1'b0;
            end else begin
                cpu_req   = ($urandom_range(0, 9) < 6);
                cpu_we    = ($urandom_range(0, 2) == 0);
                cpu_addr  = AW'($urandom_range(0, 31));
                cpu_wdata = $urandom;
            end
            if (dbg_req && !prev_dg) begin
                if ($urandom_range(0, 7) == 0) dbg_req = 1'b0;
            end else begin
                dbg_req   = ($urandom_range(0, 9) < 6);
                dbg_we    = ($urandom_range(0, 2) == 0);
                dbg_addr  = AW'($urandom_range(0, 31));
                dbg_wdata = $urandom;
            end
            settle();
            if ($urandom_range(0, 149) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                model_check();
            end
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single synchronous MainMemory port between the CPU data path (load/store from the ALU controller) and a debug/DMA port (memory dump, preload). It issues at most one access per cycle, grants round-robin when both request, and tracks each in-flight read so that read data returns to the requester that issued it. It sits between the CPU core and MainMemory and replaces the direct ALU-to-memory connection.

## Interface
- ADDR_W, 30, word address width (byte address >> 2 done upstream)
- DATA_W, 32, data width
- RD_LAT, 1, memory read latency in cycles (>= 1, <= 4)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  request accepted this cycle
- cpu_rvalid  out  1  cpu_rdata valid
- cpu_rdata  out  DATA_W  read data returned to CPU
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_* for debug port
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en read

## Operation
- Requester fields (we/addr/wdata) must be stable while req=1 and gnt=0; dropping req before gnt withdraws the request, no access made.
- Grant decision combinational each cycle: only one req -> grant it; both -> grant the one not granted last (last_owner register); none -> no grant.
- last_owner updated on every grant; reset value = DBG, so CPU wins the first contested cycle.
- In grant cycle: mem_en=1, mem_we/addr/wdata = granted requester fields; otherwise mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Exactly one of cpu_gnt/dbg_gnt high in a grant cycle; gnt is a 1-cycle pulse per accepted access; back-to-back grants allowed every cycle.
- Tag pipeline: RD_LAT-deep shift register of {valid, owner}; stage 0 loads {1, owner} on a granted read, {0, x} otherwise (writes carry no tag).
- Last stage valid -> assert that owner's rvalid; its rdata = mem_rdata; the other port's rdata = 0. No valid tag -> both rvalid 0, both rdata 0.
- Writes: no response; complete at the grant edge.

## Timing
- Read granted in cycle N -> owner rvalid high in cycle N+RD_LAT only, rdata = memory[addr].
- Write granted in cycle N -> memory updated at end of cycle N; a read of same address granted in N+1 returns new data.
- Throughput: 1 access/cycle; under continuous contention each port gets every other cycle.
- Read responses return in grant order; no reordering; up to RD_LAT reads in flight.
- Reset (any time, asynchronous): all tags cleared, rvalid=0, rdata=0, gnt=0, mem_en=0, mem_we=0, last_owner=DBG; in-flight reads are dropped and never produce rvalid, even if mem_rdata later toggles.
- Reset release: first grant possible in the first cycle with rst=0.
- Simultaneous req rise on both ports: round-robin rule above; same-cycle write from one port and read from other cannot occur (one access per cycle).

## Test plan
- Single CPU read: RD_LAT=1, cpu_req=1, cpu_addr=0x10 (mem holds 0xDEADBEEF), cycle 0 -> cpu_gnt=1, mem_en=1, mem_addr=0x10 in cycle 0; cpu_rvalid=1, cpu_rdata=0xDEADBEEF in cycle 1; dbg_rvalid=0 throughout.
- Contention after reset: both req held 4 cycles (reads, addr 1 and 2) -> grants CPU, DBG, CPU, DBG; rvalid alternates CPU, DBG one cycle later with matching data.
- Write then read: CPU write 0x20 <= 0x12345678 cycle 0, DBG read 0x20 cycle 1 -> dbg_rdata=0x12345678 in cycle 2, no cpu_rvalid.
- Latency sweep: RD_LAT=3, CPU reads addrs 0..3 back-to-back -> rvalid in cycles 3..6 with data in order.
- Reset mid-flight: RD_LAT=2, CPU read granted cycle 0, rst pulsed cycle 1 -> no rvalid in cycles 1-3, all outputs 0, next contested grant goes to CPU.
- Withdrawn request: DBG req high 1 cycle while CPU wins, then dropped -> no dbg_gnt, no memory access for DBG.
